// File: rtl/mod3_pkg.sv
// Shared state encoding and next-state function for the mod-3 ones detector.
// state | meaning
// IDLE  | no ones counted (count mod 3 = 0, no hit pending)
// S1    | one 1 seen since last wrap
// S2    | two 1s seen since last wrap
// S3    | third 1 just seen (hit); next 0 -> IDLE, next 1 -> S1
package mod3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    S1   = 2'b01,
    S2   = 2'b10,
    S3   = 2'b11
  } mod3_state_t;

  function automatic int chw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic mod3_state_t mod3_next(input mod3_state_t s, input logic din);
    mod3_state_t n;
    n = s;
    case (s)
      IDLE:    n = din ? S1 : IDLE;
      S1:      n = din ? S2 : S1;
      S2:      n = din ? S3 : S2;
      S3:      n = din ? S1 : IDLE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner, pointer moves only on a grant.
module rr_arbiter
  import mod3_pkg::*;
#(
  parameter int N = 4,
  localparam int W = chw_of(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] gnt_idx_o,
  output logic         gnt_any_o
);

  logic [W-1:0] ptr_q;
  int           idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!gnt_any_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = W'(idx);
        gnt_any_o  = 1'b1;
      end
    end
  end

  // Reset to N-1 so channel 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= W'(N - 1);
    end else if (gnt_any_o) begin
      ptr_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/mod3_stream_sched.sv
// One shared mod-3 ones-detector time-multiplexed over NCH serial streams,
// with per-channel 2-bit context and a registered, channel-tagged hit result.
module mod3_stream_sched
  import mod3_pkg::*;
#(
  parameter int NCH = 4,
  localparam int CHW = chw_of(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   req_valid,
  input  logic [NCH-1:0]   req_din,
  output logic [NCH-1:0]   req_ready,
  input  logic [NCH-1:0]   ch_en,
  input  logic [NCH-1:0]   ch_clr,
  output logic             out_valid,
  output logic [CHW-1:0]   out_chan,
  output logic             out_hit,
  output logic [2*NCH-1:0] ctx_state
);

  mod3_state_t    ctx_q [NCH];
  logic [NCH-1:0] elig;
  logic [NCH-1:0] gnt;
  logic [CHW-1:0] gnt_idx;
  logic           gnt_any;
  mod3_state_t    nxt_d;
  logic           out_valid_q;
  logic [CHW-1:0] out_chan_q;
  logic           out_hit_q;

  // A clearing channel is masked so its beat is held by the source, not lost.
  assign elig = req_valid & ch_en & ~ch_clr;

  rr_arbiter #(.N(NCH)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (elig),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign req_ready = gnt;
  assign nxt_d     = mod3_next(ctx_q[gnt_idx], req_din[gnt_idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) ctx_q[i] <= IDLE;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_hit_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_clr[i]) ctx_q[i] <= IDLE;
        else if (gnt[i]) ctx_q[i] <= nxt_d;
      end
      out_valid_q <= gnt_any;
      out_hit_q   <= gnt_any && (nxt_d == S3);
      if (gnt_any) out_chan_q <= gnt_idx;
    end
  end

  always_comb begin
    ctx_state = '0;
    for (int i = 0; i < NCH; i++) ctx_state[2*i +: 2] = ctx_q[i];
  end

  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_hit   = out_hit_q;

endmodule
